// File: rtl/cpu_pkg.sv
// Shared types and encodings for the instruction register / decoder / control FSM.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WRITE_REG
    } state_t;

    typedef enum logic [2:0] {
        I_ILL,
        I_MOVI,
        I_MOVR,
        I_ADD,
        I_CMP,
        I_AND,
        I_MVN
    } iclass_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/instr_dec.sv
// Combinational field extraction and instruction classification for a 16-bit IR.
module instr_dec
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  opcode,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [1:0]  sh,
    output logic [2:0]  rm,
    output logic [15:0] sximm8,
    output iclass_t     iclass
);

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};

    always_comb begin
        iclass = I_ILL;
        case (opcode)
            OPC_MOV: begin
                if (op == OP_MOVI)      iclass = I_MOVI;
                else if (op == OP_MOVR) iclass = I_MOVR;
            end
            OPC_ALU: begin
                case (op)
                    OP_ADD:  iclass = I_ADD;
                    OP_CMP:  iclass = I_CMP;
                    OP_AND:  iclass = I_AND;
                    default: iclass = I_MVN;
                endcase
            end
            default: iclass = I_ILL;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Instruction register plus Moore control FSM driving the regfile/shifter/ALU datapath.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WORD_W-1:0] in,
    input  logic              load,
    input  logic              s,
    output logic              w,
    output logic [2:0]        readnum,
    output logic [2:0]        writenum,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              asel,
    output logic              bsel,
    output logic              vsel,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop,
    output logic              loadc,
    output logic              loads,
    output logic [WORD_W-1:0] datapath_in
);

    state_t            state;
    logic [WORD_W-1:0] ir;

    logic [2:0]  opcode, rn, rd, rm;
    logic [1:0]  op, sh;
    logic [15:0] sximm8;
    iclass_t     iclass;

    instr_dec u_dec (
        .ir     (ir),
        .opcode (opcode),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .sximm8 (sximm8),
        .iclass (iclass)
    );

    // IR only moves in WAIT, so every execution state sees a stable instruction.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_WAIT;
            ir    <= '0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (load) ir <= in;
                    if (s) state <= S_DECODE;
                end
                S_DECODE: begin
                    case (iclass)
                        I_MOVI:             state <= S_WRITE_IMM;
                        I_ADD, I_CMP, I_AND: state <= S_GET_A;
                        I_MOVR, I_MVN:      state <= S_GET_B;
                        default:            state <= S_WAIT;
                    endcase
                end
                S_WRITE_IMM: state <= S_WAIT;
                S_GET_A:     state <= S_GET_B;
                S_GET_B:     state <= S_ALU;
                S_ALU:       state <= (iclass == I_CMP) ? S_WAIT : S_WRITE_REG;
                S_WRITE_REG: state <= S_WAIT;
                default:     state <= S_WAIT;
            endcase
        end
    end

    always_comb begin
        w           = (state == S_WAIT);
        readnum     = rn;
        writenum    = rn;
        write       = 1'b0;
        loada       = 1'b0;
        loadb       = 1'b0;
        asel        = 1'b0;
        bsel        = 1'b0;
        vsel        = 1'b0;
        loadc       = 1'b0;
        loads       = 1'b0;
        shift       = sh;
        ALUop       = (opcode == OPC_ALU) ? op : ALU_ADD;
        datapath_in = sximm8;
        case (state)
            S_WRITE_IMM: begin
                vsel  = 1'b1;
                write = 1'b1;
            end
            S_GET_A: loada = 1'b1;
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_ALU: begin
                // MOV reg passes B through the adder with a zeroed A operand.
                asel = (iclass == I_MOVR);
                if (iclass == I_CMP) loads = 1'b1;
                else                 loadc = 1'b1;
            end
            S_WRITE_REG: begin
                writenum = rd;
                write    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench: per-cycle control vectors for each instruction plus multi-cycle corner sequences.
module tb_cpu_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] in;
    logic        load, s;
    logic        w, write, loada, loadb, asel, bsel, vsel, loadc, loads;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, ALUop;
    logic [15:0] datapath_in;

    int total = 0;
    int bad   = 0;

    cpu_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in          (in),
        .load        (load),
        .s           (s),
        .w           (w),
        .readnum     (readnum),
        .writenum    (writenum),
        .write       (write),
        .loada       (loada),
        .loadb       (loadb),
        .asel        (asel),
        .bsel        (bsel),
        .vsel        (vsel),
        .shift       (shift),
        .ALUop       (ALUop),
        .loadc       (loadc),
        .loads       (loads),
        .datapath_in (datapath_in)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write;
        logic        loada;
        logic        loadb;
        logic        asel;
        logic        bsel;
        logic        vsel;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic        loadc;
        logic        loads;
        logic [15:0] dp;
    } ctrl_t;

    typedef struct {
        logic [15:0] ins;
        int          cyc;
        ctrl_t       exp;
    } row_t;

    row_t  rows[$];
    ctrl_t snap[8];

    function automatic ctrl_t mk(bit w_, bit [2:0] rdn, bit [2:0] wrn, bit wr, bit la, bit lb,
                                 bit as, bit vs, bit [1:0] sh, bit [1:0] alu, bit lc, bit ls,
                                 bit [15:0] dp);
        ctrl_t c;
        c = '{w: w_, readnum: rdn, writenum: wrn, write: wr, loada: la, loadb: lb, asel: as,
              bsel: 1'b0, vsel: vs, shift: sh, aluop: alu, loadc: lc, loads: ls, dp: dp};
        return c;
    endfunction

    function automatic ctrl_t cur();
        ctrl_t c;
        c = '{w: w, readnum: readnum, writenum: writenum, write: write, loada: loada,
              loadb: loadb, asel: asel, bsel: bsel, vsel: vsel, shift: shift, aluop: ALUop,
              loadc: loadc, loads: loads, dp: datapath_in};
        return c;
    endfunction

    task automatic add(input logic [15:0] ins, input int cyc, input ctrl_t e);
        row_t r;
        r.ins = ins; r.cyc = cyc; r.exp = e;
        rows.push_back(r);
    endtask

    task automatic check(input string nm, input ctrl_t got, input ctrl_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Load+start on one edge, then snapshot 7 cycles; every instruction is back in WAIT by cycle 6.
    task automatic run(input logic [15:0] ins);
        @(negedge clk);
        in = ins; load = 1'b1; s = 1'b1;
        @(negedge clk);
        load = 1'b0; s = 1'b0;
        snap[1] = cur();
        for (int k = 2; k < 8; k++) begin
            @(negedge clk);
            snap[k] = cur();
        end
    endtask

    ctrl_t idle0;

    initial begin
        idle0 = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);

        // MOV R0,#7
        add(16'hD007, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0007));
        add(16'hD007, 2, mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0007));
        add(16'hD007, 3, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0007));
        // MOV R1,#-1
        add(16'hD1FF, 1, mk(0, 1, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 16'hFFFF));
        add(16'hD1FF, 2, mk(0, 1, 1, 1, 0, 0, 0, 1, 3, 0, 0, 0, 16'hFFFF));
        add(16'hD1FF, 3, mk(1, 1, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 16'hFFFF));
        // ADD R2,R1,R0,LSL#1
        add(16'hA148, 1, mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0048));
        add(16'hA148, 2, mk(0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 16'h0048));
        add(16'hA148, 3, mk(0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 16'h0048));
        add(16'hA148, 4, mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 16'h0048));
        add(16'hA148, 5, mk(0, 1, 2, 1, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0048));
        add(16'hA148, 6, mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0048));
        // CMP R3,R3
        add(16'hAB03, 1, mk(0, 3, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0003));
        add(16'hAB03, 2, mk(0, 3, 3, 0, 1, 0, 0, 0, 0, 1, 0, 0, 16'h0003));
        add(16'hAB03, 3, mk(0, 3, 3, 0, 0, 1, 0, 0, 0, 1, 0, 0, 16'h0003));
        add(16'hAB03, 4, mk(0, 3, 3, 0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0003));
        add(16'hAB03, 5, mk(1, 3, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0003));
        // MVN R4,R7
        add(16'hB887, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 16'hFF87));
        add(16'hB887, 2, mk(0, 7, 0, 0, 0, 1, 0, 0, 0, 3, 0, 0, 16'hFF87));
        add(16'hB887, 3, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 16'hFF87));
        add(16'hB887, 4, mk(0, 0, 4, 1, 0, 0, 0, 0, 0, 3, 0, 0, 16'hFF87));
        add(16'hB887, 5, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 16'hFF87));
        // MOV R3,R2,LSL#1
        add(16'hC06A, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h006A));
        add(16'hC06A, 2, mk(0, 2, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 16'h006A));
        add(16'hC06A, 3, mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 16'h006A));
        add(16'hC06A, 4, mk(0, 0, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0, 16'h006A));
        add(16'hC06A, 5, mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h006A));
        // AND R5,R2,R3
        add(16'hB2A3, 1, mk(0, 2, 2, 0, 0, 0, 0, 0, 0, 2, 0, 0, 16'hFFA3));
        add(16'hB2A3, 2, mk(0, 2, 2, 0, 1, 0, 0, 0, 0, 2, 0, 0, 16'hFFA3));
        add(16'hB2A3, 3, mk(0, 3, 2, 0, 0, 1, 0, 0, 0, 2, 0, 0, 16'hFFA3));
        add(16'hB2A3, 4, mk(0, 2, 2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 16'hFFA3));
        add(16'hB2A3, 5, mk(0, 2, 5, 1, 0, 0, 0, 0, 0, 2, 0, 0, 16'hFFA3));
        add(16'hB2A3, 6, mk(1, 2, 2, 0, 0, 0, 0, 0, 0, 2, 0, 0, 16'hFFA3));
        // illegal
        add(16'h0000, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000));
        add(16'h0000, 2, idle0);

        // reset with load asserted: IR must stay 0
        reset_n = 1'b0; in = 16'hFFFF; load = 1'b1; s = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_hold", cur(), idle0);
        load = 1'b0; reset_n = 1'b1;
        @(negedge clk);
        check("after_reset", cur(), idle0);

        for (int i = 0; i < rows.size(); i++) begin
            if (i == 0 || rows[i].ins != rows[i-1].ins) run(rows[i].ins);
            check($sformatf("vec_%h_c%0d", rows[i].ins, rows[i].cyc), snap[rows[i].cyc], rows[i].exp);
        end

        // load during GET_B and stray s during ALU are both ignored
        @(negedge clk);
        in = 16'hA148; load = 1'b1; s = 1'b1;
        @(negedge clk); load = 1'b0; s = 1'b0;
        @(negedge clk);
        @(negedge clk); in = 16'hD007; load = 1'b1;
        @(negedge clk); load = 1'b0; s = 1'b1;
        check("ldign_alu", cur(), mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 16'h0048));
        @(negedge clk); s = 1'b0;
        check("ldign_wr", cur(), mk(0, 1, 2, 1, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0048));
        @(negedge clk);
        check("ldign_done", cur(), mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0048));
        @(negedge clk);
        check("sign_stay", cur(), mk(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0048));

        // s held high re-executes back-to-back
        in = 16'hD007; load = 1'b1; s = 1'b1;
        @(negedge clk); load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("b2b_wait", cur(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0007));
        @(negedge clk); s = 1'b0;
        check("b2b_decode", cur(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0007));
        @(negedge clk);
        check("b2b_write", cur(), mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0007));
        @(negedge clk);
        check("b2b_idle", cur(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0007));

        // reset mid-instruction aborts and clears IR
        in = 16'hA148; load = 1'b1; s = 1'b1;
        @(negedge clk); load = 1'b0; s = 1'b0;
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk);
        check("midrst_idle", cur(), idle0);
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_stay", cur(), idle0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
